lms_dsp_ctrl: RTL and testbench
===============================

Name: lms_dsp_ctrl

Overview:
Sequencer placed in front of and behind the lms_dsp FIR plus preamble-detect chain.
- Flushes the FIR delay line with zero samples, then streams baseband samples into the FIR while it searches for a preamble hit.
- On a hit it forwards a fixed-length burst of detector output samples; on a search timeout it re-arms.
- Exposes status pulses and counters to the register map.

Parameters:
DW, 24, sample width (I/Q packed) on all sample buses
FLUSH_LEN, 64, number of zero samples injected into the FIR on each arm
CNT_W, 16, width of capture-length, timeout and event counters

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  asynchronous reset, active-high
cfg_en  in  1  enable; low forces IDLE
cfg_threshold  in  DW  detect threshold, unsigned compare against det_data
cfg_capture_len  in  CNT_W  samples forwarded per burst; 0 is treated as 1
cfg_timeout  in  CNT_W  search timeout in input samples; 0 disables the timeout
in_data  in  DW  baseband sample
in_valid  in  1  in_data qualifier
in_error  in  2  sample error flags
fir_sink_data  out  DW  to FIR sink data
fir_sink_valid  out  1  to FIR sink valid
fir_sink_error  out  2  to FIR sink error
det_data  in  DW  from preamble-detect source data
det_valid  in  1  from preamble-detect source valid
out_data  out  DW  captured burst sample
out_valid  out  1  out_data qualifier
busy  out  1  state != IDLE
state_o  out  2  0=IDLE, 1=FLUSH, 2=SEARCH, 3=CAPTURE
capture_done  out  1  one-cycle pulse at end of a burst
timeout_pulse  out  1  one-cycle pulse on search timeout
err_sticky  out  1  in_error seen while streaming
hit_cnt  out  CNT_W  bursts captured since arm, saturating

Behaviour:
Reset and registering
- All outputs are registered.
- Reset value of every output is 0; state resets to IDLE.

IDLE
- fir_sink_valid=0 and out_valid=0.
- cfg_en=1 -> FLUSH next cycle.

Arm (entry to FLUSH from IDLE)
- Latch cfg_threshold, cfg_capture_len and cfg_timeout into shadow registers.
- Clear err_sticky and hit_cnt.
- Shadow values hold until the next arm.

FLUSH
- Drive fir_sink_valid=1, fir_sink_data=0, fir_sink_error=0 every cycle for exactly FLUSH_LEN cycles.
- in_valid samples arriving during FLUSH are dropped.
- det_valid is ignored.
- After the FLUSH_LEN-th cycle -> SEARCH.

SEARCH
- Each in_valid sample is forwarded one cycle later: fir_sink_data=in_data, fir_sink_error=in_error, fir_sink_valid=1.
- When no in_valid arrives, fir_sink_valid=0 that cycle.
- in_valid with in_error != 0 sets err_sticky in SEARCH or CAPTURE.
- The timeout counter increments per in_valid sample.
- Hit = det_valid & (det_data >= threshold). A hit moves to CAPTURE. The hitting sample is the first burst sample: out_valid=1, out_data=det_data one cycle after the hit.
- Timeout: counter reaches cfg_timeout with cfg_timeout != 0. Result: timeout_pulse=1 and the state returns to FLUSH (re-arm flush, shadow registers not reloaded).
- A hit and a timeout in the same cycle: the hit wins and no timeout_pulse is issued.
- The timeout counter clears on entry to SEARCH.

CAPTURE
- Input streaming to the FIR continues as in SEARCH.
- Each det_valid sample is forwarded to out_data/out_valid with 1-cycle latency, regardless of threshold.
- The burst counter counts forwarded samples, including the hitting sample.
- When the count reaches capture_len:
  - the last sample is emitted;
  - capture_done pulses in the same cycle as the last out_valid;
  - hit_cnt increments (saturating at all-ones);
  - the state returns to SEARCH with the timeout counter cleared.
- capture_len=1: the hit sample alone forms the burst; capture_done is issued on it.

cfg_en deassert
- cfg_en=0 in any state -> IDLE next cycle; this is an abort.
- On abort: out_valid and fir_sink_valid go to 0 from the next cycle, no capture_done, counters hold.
- Re-asserting cfg_en re-arms, with a new latch and a new flush.

Asynchronous reset mid-operation
- Immediate return to IDLE with all outputs 0.
- There is no partial burst continuation after reset.

Counter widths
- Counters are CNT_W bits.
- The timeout compare is equality on the CNT_W-bit counter.
- The FLUSH counter is clog2(FLUSH_LEN+1) bits.

Test Plan:
- Reset, then cfg_en=1 with FLUSH_LEN=64: exactly 64 cycles of fir_sink_valid=1 with data 0, state_o=1, then state_o=2; in_valid samples during the flush do not appear on fir_sink.
- SEARCH, threshold=0x000100, det_data=0x0000FF then 0x000100, capture_len=4: the first sample gives no hit; the second starts the burst; exactly 4 out_valid; capture_done on the 4th; hit_cnt=1; state back to 2.
- cfg_timeout=10, no hit: timeout_pulse exactly on the 10th in_valid sample after SEARCH entry, followed by a 64-cycle flush.
- Hit on the same sample as the 10th timeout count: CAPTURE entered, timeout_pulse stays 0.
- in_valid with in_error=2'b01 in SEARCH: fir_sink_error=01 one cycle later and err_sticky=1; err_sticky cleared only after cfg_en 0->1 re-arm.
- cfg_en dropped on the 2nd sample of an 8-sample burst: out_valid=0 from the next cycle, no capture_done, state_o=0. Reset asserted mid-CAPTURE: all outputs 0 asynchronously.

Source files
------------

// File: rtl/lms_dsp_ctrl_if.sv
// Sample-stream bundle around the lms_dsp FIR / preamble-detect chain.
// Ports: baseband in, FIR sink out, detector source in, burst out.
`timescale 1ns/1ps
interface lms_dsp_ctrl_if #(
    parameter int DW = 24
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic [1:0]    in_error;
    logic [DW-1:0] fir_sink_data;
    logic          fir_sink_valid;
    logic [1:0]    fir_sink_error;
    logic [DW-1:0] det_data;
    logic          det_valid;
    logic [DW-1:0] out_data;
    logic          out_valid;

    modport master (
        output in_data, in_valid, in_error,
        output det_data, det_valid,
        input  fir_sink_data, fir_sink_valid, fir_sink_error,
        input  out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_error,
        input  det_data, det_valid,
        output fir_sink_data, fir_sink_valid, fir_sink_error,
        output out_data, out_valid
    );
endinterface

// File: rtl/lms_dsp_ctrl.sv
// Flush / search / capture sequencer around the lms_dsp FIR and detector.
// Ports: clk_clk, reset_reset, cfg_* config, bus (streams), status outputs.
`timescale 1ns/1ps
module lms_dsp_ctrl #(
    parameter int DW        = 24,
    parameter int FLUSH_LEN = 64,
    parameter int CNT_W     = 16
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic             cfg_en,
    input  logic [DW-1:0]    cfg_threshold,
    input  logic [CNT_W-1:0] cfg_capture_len,
    input  logic [CNT_W-1:0] cfg_timeout,
    lms_dsp_ctrl_if.slave    bus,
    output logic             busy,
    output logic [1:0]       state_o,
    output logic             capture_done,
    output logic             timeout_pulse,
    output logic             err_sticky,
    output logic [CNT_W-1:0] hit_cnt
);
    localparam int FCW = $clog2(FLUSH_LEN + 1);
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLUSH   = 2'd1,
        SEARCH  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [FCW-1:0]   flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [DW-1:0]    thr_q, thr_d;
    logic [CNT_W-1:0] cap_q, cap_d;
    logic [CNT_W-1:0] tmo_lim_q, tmo_lim_d;
    logic [DW-1:0]    fir_data_q, fir_data_d;
    logic             fir_valid_q, fir_valid_d;
    logic [1:0]       fir_err_q, fir_err_d;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tpulse_q, tpulse_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] hit_q, hit_d;

    logic [CNT_W-1:0] tmo_next;
    logic [CNT_W-1:0] burst_next;
    logic [CNT_W-1:0] cap_eff;
    logic [CNT_W-1:0] hit_inc;
    logic             hit;
    logic             streaming;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        burst_cnt_d = burst_cnt_q;
        thr_d       = thr_q;
        cap_d       = cap_q;
        tmo_lim_d   = tmo_lim_q;
        fir_data_d  = '0;
        fir_valid_d = 1'b0;
        fir_err_d   = '0;
        out_data_d  = '0;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        tpulse_d    = 1'b0;
        err_d       = err_q;
        hit_d       = hit_q;

        tmo_next   = tmo_cnt_q + CNT_W'(bus.in_valid);
        burst_next = burst_cnt_q + CNT_W'(1);
        cap_eff    = (cap_q == '0) ? CNT_W'(1) : cap_q;
        hit_inc    = (&hit_q) ? hit_q : hit_q + CNT_W'(1);
        hit        = bus.det_valid && (bus.det_data >= thr_q);
        streaming  = (state_q == SEARCH) || (state_q == CAPTURE);

        // Input streaming is common to SEARCH and CAPTURE; a timeout
        // below overrides it with the re-arm flush.
        if (cfg_en && streaming && bus.in_valid) begin
            fir_valid_d = 1'b1;
            fir_data_d  = bus.in_data;
            fir_err_d   = bus.in_error;
            if (bus.in_error != 2'b00) begin
                err_d = 1'b1;
            end
        end

        if (!cfg_en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                    fir_valid_d = 1'b1;
                    thr_d       = cfg_threshold;
                    cap_d       = cfg_capture_len;
                    tmo_lim_d   = cfg_timeout;
                    err_d       = 1'b0;
                    hit_d       = '0;
                end
                FLUSH: begin
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_d   = SEARCH;
                        tmo_cnt_d = '0;
                    end else begin
                        flush_cnt_d = flush_cnt_q + FCW'(1);
                        fir_valid_d = 1'b1;
                    end
                end
                SEARCH: begin
                    if (hit) begin
                        out_valid_d = 1'b1;
                        out_data_d  = bus.det_data;
                        burst_cnt_d = CNT_W'(1);
                        if (cap_eff == CNT_W'(1)) begin
                            done_d    = 1'b1;
                            hit_d     = hit_inc;
                            tmo_cnt_d = '0;
                        end else begin
                            state_d = CAPTURE;
                        end
                    end else if (bus.in_valid && tmo_lim_q != '0
                                 && tmo_next == tmo_lim_q) begin
                        tpulse_d    = 1'b1;
                        state_d     = FLUSH;
                        flush_cnt_d = '0;
                        fir_valid_d = 1'b1;
                        fir_data_d  = '0;
                        fir_err_d   = '0;
                    end else begin
                        tmo_cnt_d = tmo_next;
                    end
                end
                CAPTURE: begin
                    if (bus.det_valid) begin
                        out_valid_d = 1'b1;
                        out_data_d  = bus.det_data;
                        burst_cnt_d = burst_next;
                        if (burst_next == cap_eff) begin
                            done_d    = 1'b1;
                            hit_d     = hit_inc;
                            state_d   = SEARCH;
                            tmo_cnt_d = '0;
                        end
                    end
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            burst_cnt_q <= '0;
            thr_q       <= '0;
            cap_q       <= '0;
            tmo_lim_q   <= '0;
            fir_data_q  <= '0;
            fir_valid_q <= 1'b0;
            fir_err_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tpulse_q    <= 1'b0;
            err_q       <= 1'b0;
            hit_q       <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            thr_q       <= thr_d;
            cap_q       <= cap_d;
            tmo_lim_q   <= tmo_lim_d;
            fir_data_q  <= fir_data_d;
            fir_valid_q <= fir_valid_d;
            fir_err_q   <= fir_err_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tpulse_q    <= tpulse_d;
            err_q       <= err_d;
            hit_q       <= hit_d;
        end
    end

    assign bus.fir_sink_data  = fir_data_q;
    assign bus.fir_sink_valid = fir_valid_q;
    assign bus.fir_sink_error = fir_err_q;
    assign bus.out_data       = out_data_q;
    assign bus.out_valid      = out_valid_q;
    assign busy               = busy_q;
    assign state_o            = state_q;
    assign capture_done       = done_q;
    assign timeout_pulse      = tpulse_q;
    assign err_sticky         = err_q;
    assign hit_cnt            = hit_q;
endmodule

// File: tb/tb_lms_dsp_ctrl.sv
// Scoreboard bench for lms_dsp_ctrl: flush, search, capture, timeout,
// error flag, abort and asynchronous reset scenarios.
`timescale 1ns/1ps
module tb_lms_dsp_ctrl;
    localparam int DW = 24;
    localparam int FL = 64;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_en = 1'b0;
    logic [DW-1:0] cfg_threshold = '0;
    logic [CW-1:0] cfg_capture_len = '0;
    logic [CW-1:0] cfg_timeout = '0;
    logic          busy;
    logic [1:0]    state_o;
    logic          capture_done;
    logic          timeout_pulse;
    logic          err_sticky;
    logic [CW-1:0] hit_cnt;

    lms_dsp_ctrl_if #(.DW(DW)) bus ();

    lms_dsp_ctrl #(.DW(DW), .FLUSH_LEN(FL), .CNT_W(CW)) dut (
        .clk_clk         (clk),
        .reset_reset     (rst),
        .cfg_en          (cfg_en),
        .cfg_threshold   (cfg_threshold),
        .cfg_capture_len (cfg_capture_len),
        .cfg_timeout     (cfg_timeout),
        .bus             (bus.slave),
        .busy            (busy),
        .state_o         (state_o),
        .capture_done    (capture_done),
        .timeout_pulse   (timeout_pulse),
        .err_sticky      (err_sticky),
        .hit_cnt         (hit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [1:0]    e;
    } fir_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          done;
    } out_t;

    fir_t fir_q[$];
    out_t out_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int flush_seen = 0;
    int tmo_seen = 0;
    int done_seen = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_fir(input logic [DW-1:0] d, input logic [1:0] e);
        fir_t t;
        t.d = d;
        t.e = e;
        fir_q.push_back(t);
    endtask

    task automatic push_out(input logic [DW-1:0] d, input logic done);
        out_t t;
        t.d = d;
        t.done = done;
        out_q.push_back(t);
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents a sample.
    always @(negedge clk) begin
        fir_t f;
        out_t o;
        if (bus.fir_sink_valid) begin
            chk("fir_avail", 32'(fir_q.size() != 0), 32'd1);
            if (fir_q.size() != 0) begin
                f = fir_q.pop_front();
                chk("fir_data", 32'(bus.fir_sink_data), 32'(f.d));
                chk("fir_err", 32'(bus.fir_sink_error), 32'(f.e));
            end
        end
        if (bus.out_valid) begin
            chk("out_avail", 32'(out_q.size() != 0), 32'd1);
            if (out_q.size() != 0) begin
                o = out_q.pop_front();
                chk("out_data", 32'(bus.out_data), 32'(o.d));
                chk("out_done", 32'(capture_done), 32'(o.done));
            end
        end else if (capture_done) begin
            chk("done_wo_valid", 32'(bus.out_valid), 32'd1);
        end
        if (state_o == 2'd1 && bus.fir_sink_valid) flush_seen++;
        if (timeout_pulse) tmo_seen++;
        if (capture_done) done_seen++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic iv, input logic [DW-1:0] id,
                       input logic [1:0] ie, input logic dv,
                       input logic [DW-1:0] dd);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.in_error  = ie;
        bus.det_valid = dv;
        bus.det_data  = dd;
        step();
        bus.in_valid  = 1'b0;
        bus.in_error  = 2'b00;
        bus.det_valid = 1'b0;
    endtask

    // Feeds junk samples during the flush; none may reach the FIR sink.
    task automatic run_flush();
        flush_seen = 0;
        for (int i = 0; i < 200; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 24'hABCDEF;
            bus.in_error = 2'b11;
            step();
            if (state_o == 2'd2) break;
        end
        bus.in_valid = 1'b0;
        bus.in_error = 2'b00;
        chk("flush_to_search", 32'(state_o), 32'd2);
        chk("flush_len", 32'(flush_seen), 32'(FL));
    endtask

    task automatic arm(input logic [DW-1:0] thr, input logic [CW-1:0] cap,
                       input logic [CW-1:0] tmo);
        cfg_threshold   = thr;
        cfg_capture_len = cap;
        cfg_timeout     = tmo;
        cfg_en          = 1'b1;
        repeat (FL) push_fir('0, 2'b00);
        run_flush();
        chk("arm_err_clr", 32'(err_sticky), 32'd0);
        chk("arm_hit_clr", 32'(hit_cnt), 32'd0);
        chk("arm_busy", 32'(busy), 32'd1);
    endtask

    task automatic disarm();
        cfg_en = 1'b0;
        step();
        chk("disarm_state", 32'(state_o), 32'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_error  = 2'b00;
        bus.det_valid = 1'b0;
        bus.det_data  = '0;
        #1 rst = 1'b1;
        #2;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fir_v", 32'(bus.fir_sink_valid), 32'd0);
        chk("rst_out_v", 32'(bus.out_valid), 32'd0);
        chk("rst_hit", 32'(hit_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // Flush, then a sub-threshold sample, then a 4-sample burst.
        arm(24'h000100, 16'd4, 16'd0);
        cfg_threshold = 24'hFFFFFF;
        push_fir(24'h11, 2'b00);
        cyc(1'b1, 24'h11, 2'b00, 1'b1, 24'h0000FF);
        chk("no_hit_state", 32'(state_o), 32'd2);
        push_fir(24'h12, 2'b00);
        push_out(24'h000100, 1'b0);
        cyc(1'b1, 24'h12, 2'b00, 1'b1, 24'h000100);
        chk("hit_state", 32'(state_o), 32'd3);
        push_fir(24'h13, 2'b00);
        push_out(24'h000005, 1'b0);
        cyc(1'b1, 24'h13, 2'b00, 1'b1, 24'h000005);
        push_out(24'h000006, 1'b0);
        cyc(1'b0, '0, 2'b00, 1'b1, 24'h000006);
        cyc(1'b0, '0, 2'b00, 1'b0, '0);
        push_out(24'h000007, 1'b1);
        cyc(1'b0, '0, 2'b00, 1'b1, 24'h000007);
        chk("burst_done", 32'(capture_done), 32'd1);
        cyc(1'b0, '0, 2'b00, 1'b0, '0);
        chk("burst_state", 32'(state_o), 32'd2);
        chk("burst_hit_cnt", 32'(hit_cnt), 32'd1);
        chk("burst_done_cnt", 32'(done_seen), 32'd1);

        // Error flag forwarded and sticky across disarm.
        push_fir(24'h21, 2'b01);
        cyc(1'b1, 24'h21, 2'b01, 1'b0, '0);
        chk("err_set", 32'(err_sticky), 32'd1);
        disarm();
        chk("err_hold", 32'(err_sticky), 32'd1);

        // Timeout after 10 input samples, then re-arm flush.
        arm(24'h000100, 16'd4, 16'd10);
        for (int i = 1; i <= 9; i++) begin
            push_fir(24'h30 + 24'(i), 2'b00);
            cyc(1'b1, 24'h30 + 24'(i), 2'b00, 1'b0, '0);
            if (i % 2 == 1) cyc(1'b0, '0, 2'b00, 1'b0, '0);
        end
        chk("tmo_not_yet", 32'(tmo_seen), 32'd0);
        repeat (FL) push_fir('0, 2'b00);
        cyc(1'b1, 24'h3A, 2'b00, 1'b0, '0);
        chk("tmo_pulse", 32'(timeout_pulse), 32'd1);
        chk("tmo_state", 32'(state_o), 32'd1);
        run_flush();
        chk("tmo_once", 32'(tmo_seen), 32'd1);

        // Hit on the 10th sample beats the timeout.
        for (int i = 1; i <= 9; i++) begin
            push_fir(24'h40 + 24'(i), 2'b00);
            cyc(1'b1, 24'h40 + 24'(i), 2'b00, 1'b0, '0);
        end
        push_fir(24'h4A, 2'b00);
        push_out(24'h000200, 1'b0);
        cyc(1'b1, 24'h4A, 2'b00, 1'b1, 24'h000200);
        chk("race_state", 32'(state_o), 32'd3);
        chk("race_no_tmo", 32'(timeout_pulse), 32'd0);
        push_out(24'h000201, 1'b0);
        cyc(1'b0, '0, 2'b00, 1'b1, 24'h000201);
        push_out(24'h000202, 1'b0);
        cyc(1'b0, '0, 2'b00, 1'b1, 24'h000202);
        push_out(24'h000203, 1'b1);
        cyc(1'b0, '0, 2'b00, 1'b1, 24'h000203);
        chk("race_end_state", 32'(state_o), 32'd2);
        chk("race_hit_cnt", 32'(hit_cnt), 32'd1);
        chk("race_tmo_cnt", 32'(tmo_seen), 32'd1);

        // Abort on the 2nd sample of an 8-sample burst.
        disarm();
        arm(24'h000100, 16'd8, 16'd0);
        push_out(24'h000300, 1'b0);
        cyc(1'b0, '0, 2'b00, 1'b1, 24'h000300);
        chk("abort_cap", 32'(state_o), 32'd3);
        cfg_en = 1'b0;
        cyc(1'b0, '0, 2'b00, 1'b1, 24'h000301);
        chk("abort_state", 32'(state_o), 32'd0);
        chk("abort_out_v", 32'(bus.out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_no_done", 32'(done_seen), 32'd2);
        chk("abort_hit_hold", 32'(hit_cnt), 32'd0);

        // Capture length 0 behaves as 1.
        arm(24'h000100, 16'd0, 16'd0);
        cyc(1'b0, '0, 2'b00, 1'b1, 24'h0000FF);
        push_out(24'h000350, 1'b1);
        cyc(1'b0, '0, 2'b00, 1'b1, 24'h000350);
        chk("len1_state", 32'(state_o), 32'd2);
        chk("len1_hit", 32'(hit_cnt), 32'd1);
        push_out(24'h000351, 1'b1);
        cyc(1'b0, '0, 2'b00, 1'b1, 24'h000351);
        chk("len1_hit2", 32'(hit_cnt), 32'd2);

        // Asynchronous reset mid-capture.
        disarm();
        arm(24'h000100, 16'd8, 16'd0);
        push_fir(24'h55, 2'b00);
        push_out(24'h000400, 1'b0);
        cyc(1'b1, 24'h55, 2'b00, 1'b1, 24'h000400);
        push_out(24'h000401, 1'b0);
        cyc(1'b0, '0, 2'b00, 1'b1, 24'h000401);
        chk("pre_rst_out_v", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_state", 32'(state_o), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_out_v", 32'(bus.out_valid), 32'd0);
        chk("arst_out_d", 32'(bus.out_data), 32'd0);
        chk("arst_fir_v", 32'(bus.fir_sink_valid), 32'd0);
        cfg_en = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("post_rst_state", 32'(state_o), 32'd0);

        chk("fir_q_empty", 32'(fir_q.size()), 32'd0);
        chk("out_q_empty", 32'(out_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
